// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall bus layout,
// canonical stall patterns and FSM state encoding.
package pipe_ctrl_pkg;

    localparam int unsigned StallBus = 6;

    typedef logic [StallBus-1:0] stall_t;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit order: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
    localparam stall_t StallNone = 6'b000000;
    localparam stall_t StallId   = 6'b000111;
    localparam stall_t StallEx   = 6'b001111;
    localparam stall_t StallMem  = 6'b011111;
    localparam stall_t StallAll  = 6'b111111;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StDiv   = 2'b01,
        StFlush = 2'b10
    } state_e;

    // The deepest requesting stage wins; each pattern freezes itself and everything upstream.
    function automatic stall_t stall_pattern(input logic req_id, input logic req_ex,
                                             input logic req_mem);
        if (req_mem) begin
            return StallMem;
        end else if (req_ex) begin
            return StallEx;
        end else if (req_id) begin
            return StallId;
        end
        return StallNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        div_req;
    logic        div_done;
    logic        excp_req;
    logic [31:0] excp_pc;
    stall_t      stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_start;
    logic        div_annul;
    logic [15:0] stall_cnt;
    logic        stall_timeout;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, div_req, div_done, excp_req, excp_pc,
        input  stall, flush, new_pc, div_start, div_annul, stall_cnt, stall_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, div_req, div_done, excp_req, excp_pc,
        output stall, flush, new_pc, div_start, div_annul, stall_cnt, stall_timeout
    );

endinterface

// File: rtl/stall_perf_cnt.sv
// Stall statistics: saturating total of stalled cycles plus a sticky watchdog
// that fires after TIMEOUT_CYC consecutive stalled cycles.
module stall_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    output logic [15:0] stall_cnt,
    output logic        stall_timeout
);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  consec_q, consec_d;
    logic        timeout_q, timeout_d;
    logic        stalled;

    assign stalled = (stall_pc == Stop);

    always_comb begin
        cnt_d     = cnt_q;
        consec_d  = '0;
        timeout_d = timeout_q;
        if (stalled && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (stalled) begin
            consec_d = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
        end
        // Flag rises together with the count reaching the limit, then sticks until reset.
        if (32'(consec_d) == TIMEOUT_CYC) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            consec_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            consec_q  <= consec_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cnt     = cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: merges stage stall requests, sequences
// multi-cycle divides and turns exceptions into a one-cycle registered flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic        flush_q;
    logic [31:0] new_pc_q, new_pc_d;
    stall_t      stall;
    stall_t      req_pat;
    logic        div_start;
    logic        div_annul;
    logic [15:0] stall_cnt;
    logic        stall_timeout;

    assign req_pat = stall_pattern(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= (state_d == StFlush);
            new_pc_q <= new_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (bus.excp_req) begin
                    state_d = StFlush;
                end else if (bus.div_req) begin
                    state_d = StDiv;
                end
            end
            StDiv: begin
                if (bus.excp_req) begin
                    state_d = StFlush;
                end else if (bus.div_done) begin
                    state_d = StRun;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
        // The handler address is latched only on the edge that enters the flush state.
        new_pc_d = (state_d == StFlush) ? bus.excp_pc : new_pc_q;
    end

    always_comb begin
        stall     = StallNone;
        div_start = 1'b0;
        div_annul = 1'b0;
        if (rst) begin
            unique case (state_q)
                StRun: begin
                    if (bus.excp_req) begin
                        stall = StallAll;
                    end else if (bus.div_req) begin
                        div_start = 1'b1;
                        stall     = req_pat | StallEx;
                    end else begin
                        stall = req_pat;
                    end
                end
                StDiv: begin
                    if (bus.excp_req) begin
                        div_annul = 1'b1;
                        stall     = StallAll;
                    end else if (bus.div_done) begin
                        stall = req_pat;
                    end else begin
                        stall = req_pat | StallEx;
                    end
                end
                StFlush: stall = StallNone;
                default: stall = StallNone;
            endcase
        end
    end

    stall_perf_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_stall_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .stall_pc     (stall[0]),
        .stall_cnt    (stall_cnt),
        .stall_timeout(stall_timeout)
    );

    assign bus.stall         = stall;
    assign bus.div_start     = div_start;
    assign bus.div_annul     = div_annul;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.stall_timeout = stall_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, divide
// sequencing, exception flush, reset behaviour and the stall watchdog.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.div_req      = 1'b0;
        bus.div_done     = 1'b0;
        bus.excp_req     = 1'b0;
        bus.excp_pc      = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {id, ex, mem, expected stall}
    logic [8:0] prio_tbl [4] = '{
        {3'b101, 6'b011111},
        {3'b010, 6'b001111},
        {3'b110, 6'b001111},
        {3'b111, 6'b011111}
    };

    initial begin
        int ds;
        int st;
        logic [8:0] v;

        // Reset state, with requests asserted to show outputs are gated
        clr();
        bus.stallreq_mem = 1'b1;
        bus.div_req      = 1'b1;
        #12;
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_div_start", 32'(bus.div_start), 32'h0);
        check("rst_div_annul", 32'(bus.div_annul), 32'h0);
        check("rst_flush", 32'(bus.flush), 32'h0);
        check("rst_new_pc", bus.new_pc, 32'h0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        check("rst_timeout", 32'(bus.stall_timeout), 32'h0);
        clr();
        #1;
        rst = 1'b1;
        step();

        // Single load-use stall
        bus.stallreq_id = 1'b1;
        #1;
        check("id_stall", 32'(bus.stall), 32'h07);
        step();
        clr();
        #1;
        check("id_cnt", 32'(bus.stall_cnt), 32'd1);
        check("idle_stall", 32'(bus.stall), 32'h0);

        // Priority combinations
        for (int i = 0; i < 4; i++) begin
            v = prio_tbl[i];
            bus.stallreq_id  = v[8];
            bus.stallreq_ex  = v[7];
            bus.stallreq_mem = v[6];
            #1;
            check($sformatf("prio_%0d", i), 32'(bus.stall), 32'(v[5:0]));
            step();
        end
        clr();
        #1;
        check("prio_cnt", 32'(bus.stall_cnt), 32'd5);

        // Exception in run state beats a divide request
        bus.div_req     = 1'b1;
        bus.excp_req    = 1'b1;
        bus.stallreq_id = 1'b1;
        bus.excp_pc     = 32'h8000_0180;
        #1;
        check("run_excp_stall", 32'(bus.stall), 32'h3F);
        check("run_excp_no_start", 32'(bus.div_start), 32'h0);
        step();
        check("flush1", 32'(bus.flush), 32'h1);
        check("flush1_pc", bus.new_pc, 32'h8000_0180);
        check("flush1_stall", 32'(bus.stall), 32'h0);
        check("flush1_no_start", 32'(bus.div_start), 32'h0);
        step();
        clr();
        #1;
        check("flush1_end", 32'(bus.flush), 32'h0);
        check("flush1_pc_hold", bus.new_pc, 32'h8000_0180);
        check("flush1_cnt", 32'(bus.stall_cnt), 32'd6);

        // Divide: start cycle plus five waiting cycles, then done
        bus.div_req = 1'b1;
        ds = 0;
        st = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.div_start) ds++;
            if (bus.stall == 6'b001111) st++;
            step();
        end
        bus.div_done = 1'b1;
        #1;
        check("div_done_stall", 32'(bus.stall), 32'h0);
        check("div_done_no_start", 32'(bus.div_start), 32'h0);
        step();
        clr();
        #1;
        check("div_back_run", 32'(bus.stall), 32'h0);
        check("div_start_cnt", 32'(ds), 32'd1);
        check("div_stall_cycles", 32'(st), 32'd6);
        check("div_cnt", 32'(bus.stall_cnt), 32'd12);

        // Exception during divide, same cycle as div_done
        bus.div_req = 1'b1;
        step();
        bus.stallreq_mem = 1'b1;
        #1;
        check("div_mem_stall", 32'(bus.stall), 32'h1F);
        step();
        bus.stallreq_mem = 1'b0;
        bus.excp_req     = 1'b1;
        bus.excp_pc      = 32'hBFC0_0380;
        bus.div_done     = 1'b1;
        #1;
        check("div_excp_annul", 32'(bus.div_annul), 32'h1);
        check("div_excp_stall", 32'(bus.stall), 32'h3F);
        check("div_excp_no_start", 32'(bus.div_start), 32'h0);
        step();
        clr();
        #1;
        check("flush2", 32'(bus.flush), 32'h1);
        check("flush2_pc", bus.new_pc, 32'hBFC0_0380);
        check("flush2_stall", 32'(bus.stall), 32'h0);
        check("flush2_no_annul", 32'(bus.div_annul), 32'h0);
        check("flush2_cnt", 32'(bus.stall_cnt), 32'd15);
        step();
        check("flush2_end", 32'(bus.flush), 32'h0);
        check("flush2_pc_hold", bus.new_pc, 32'hBFC0_0380);

        // Reset in the middle of a divide
        bus.div_req = 1'b1;
        step();
        #1;
        check("mid_div_stall", 32'(bus.stall), 32'h0F);
        rst = 1'b0;
        #1;
        check("mid_rst_annul", 32'(bus.div_annul), 32'h0);
        check("mid_rst_stall", 32'(bus.stall), 32'h0);
        check("mid_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        check("mid_rst_new_pc", bus.new_pc, 32'h0);
        clr();
        #2;
        rst = 1'b1;
        step();
        #1;
        check("mid_rst_run", 32'(bus.stall), 32'h0);

        // Watchdog
        bus.stallreq_mem = 1'b1;
        repeat (199) step();
        check("wd_199", 32'(bus.stall_timeout), 32'h0);
        check("wd_cnt_199", 32'(bus.stall_cnt), 32'd199);
        step();
        check("wd_200", 32'(bus.stall_timeout), 32'h1);
        clr();
        repeat (5) step();
        check("wd_sticky", 32'(bus.stall_timeout), 32'h1);
        check("wd_cnt_hold", 32'(bus.stall_cnt), 32'd200);
        rst = 1'b0;
        #1;
        check("wd_rst", 32'(bus.stall_timeout), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 200, consecutive-stall cycles after which stall_timeout sets.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 stallreq_id  input  1  decode hazard (load-use) stall request.
REQ-005 stallreq_ex  input  1  execute-stage stall request (non-divide multi-cycle op).
REQ-006 stallreq_mem  input  1  data-bus wait stall request.
REQ-007 div_req  input  1  execute stage holds a divide instruction.
REQ-008 div_done  input  1  divider result valid, one-cycle pulse.
REQ-009 excp_req  input  1  exception/flush request from memory stage.
REQ-010 excp_pc  input  32  handler address accompanying excp_req.
REQ-011 stall  output  `StallBus (6)  per-stage hold: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb; 1=`Stop.
REQ-012 flush  output  1  pipeline flush pulse, registered.
REQ-013 new_pc  output  32  redirect address, valid when flush=1, registered.
REQ-014 div_start  output  1  divider start pulse.
REQ-015 div_annul  output  1  abort outstanding divide.
REQ-016 stall_cnt  output  16  total cycles with stall[0]=1, saturating.
REQ-017 stall_timeout  output  1  sticky watchdog flag.

Function
REQ-018 FSM states: S_RUN, S_DIV, S_FLUSH; stall, div_start, div_annul combinational from state and inputs.
REQ-019 Priority pattern P(req): stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-020 S_RUN, excp_req=1: stall=6'b111111, capture excp_pc, next S_FLUSH; div_req ignored.
REQ-021 S_RUN, excp_req=0, div_req=1: div_start=1 this cycle, stall=P|6'b001111, next S_DIV.
REQ-022 S_RUN otherwise: stall=P, stay S_RUN.
REQ-023 S_DIV, excp_req=1: div_annul=1, stall=6'b111111, capture excp_pc, next S_FLUSH (excp beats div_done same cycle).
REQ-024 S_DIV, div_done=1: stall=P, next S_RUN; div_req in this cycle ignored (no restart).
REQ-025 S_DIV otherwise: stall=P|6'b001111, div_start=0, stay.
REQ-026 S_FLUSH: flush=1, new_pc=captured value, stall=6'b000000, all requests ignored, next S_RUN; exactly one cycle.
REQ-027 flush and new_pc registered: both change only on the edge entering/leaving S_FLUSH; new_pc holds last value after flush.
REQ-028 stall_cnt increments each cycle stall[0]=1, saturates at 16'hFFFF.
REQ-029 Consecutive counter (8 bit, saturating) increments while stall[0]=1, clears when stall[0]=0; stall_timeout sets when count reaches TIMEOUT_CYC, stays 1 until reset.
REQ-030 div_start never asserted in same cycle as div_annul or flush.

Reset
REQ-031 rst=0 asynchronously: state S_RUN, flush=0, new_pc=32'h0, stall_cnt=0, consecutive count=0, stall_timeout=0.
REQ-032 While rst=0: stall=6'b000000, div_start=0, div_annul=0.
REQ-033 Reset mid-divide: return to S_RUN with no div_annul pulse; divider reset by same rst.

Structure
REQ-034 defines.v holds `StallBus, `Stop/`NoStop, the four stall pattern constants, state encodings.
REQ-035 One sub-module stall_perf_cnt holds stall_cnt and watchdog; FSM and stall mux stay in pipe_ctrl.

Verification
REQ-036 Release rst, stallreq_id=1 one cycle -> stall=6'b000111 that cycle, stall_cnt=1 after.
REQ-037 stallreq_id=1, stallreq_mem=1 same cycle -> stall=6'b011111.
REQ-038 S_RUN div_req=1, div_done after 5 cycles -> div_start one cycle, stall=6'b001111 for 6 cycles, then 6'b000000, state S_RUN.
REQ-039 In S_DIV, excp_req=1, excp_pc=32'hBFC00380, div_done=1 same cycle -> div_annul=1, stall=6'b111111; next cycle flush=1, new_pc=32'hBFC00380, stall=0.
REQ-040 Hold stallreq_mem=1 for 200 cycles -> stall_timeout=1 at cycle 200, remains 1 after release; rst=0 -> clears.
